// File: rtl/fifo_serial_arbiter.sv
// Two-requester arbiter that serialises each accepted pixel result into a
// coordinate word followed by a pixel word on a shared output FIFO.
module fifo_serial_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             req0_valid,
    input  logic [9:0]       req0_x,
    input  logic [9:0]       req0_y,
    input  logic [7:0]       req0_left,
    input  logic [7:0]       req0_right,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [9:0]       req1_x,
    input  logic [9:0]       req1_y,
    input  logic [7:0]       req1_left,
    input  logic [7:0]       req1_right,
    output logic             req1_ready,
    input  logic             outfifo_full,
    output logic             outfifo_wrreq,
    output logic [31:0]      outfifo_data,
    output logic             grant_id,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_COORD = 2'd1,
        SEND_PIX   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [7:0]       left_q, left_d, right_q, right_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic win1;
    logic grant_ok;
    logic accept0;
    logic accept1;
    logic wr;

    // On a tie, round-robin hands the grant to whoever was not served last.
    assign win1     = req1_valid & (~req0_valid | ((FIXED_PRIO == 0) & ~last_q));
    // reset_n gates the handshake so readies fall the instant reset asserts.
    assign grant_ok = reset_n & enable & (state_q == IDLE);
    assign accept0  = grant_ok & req0_valid & ~win1;
    assign accept1  = grant_ok & win1;
    assign wr       = (state_q != IDLE) & ~outfifo_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            left_q  <= '0;
            right_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            left_q  <= left_d;
            right_q <= right_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        left_d  = left_q;
        right_d = right_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept0 | accept1) begin
                    x_d     = win1 ? req1_x     : req0_x;
                    y_d     = win1 ? req1_y     : req0_y;
                    left_d  = win1 ? req1_left  : req0_left;
                    right_d = win1 ? req1_right : req0_right;
                    grant_d = win1;
                    last_d  = win1;
                    state_d = SEND_COORD;
                end
            end
            SEND_COORD: begin
                if (wr) begin
                    state_d = SEND_PIX;
                end
            end
            SEND_PIX: begin
                if (wr) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready    = accept0;
        req1_ready    = accept1;
        outfifo_wrreq = wr;
        outfifo_data  = 32'd0;
        case (state_q)
            SEND_COORD: outfifo_data = {1'b0, 5'b0, y_q, 6'b0, x_q};
            SEND_PIX:   outfifo_data = {1'b1, 15'b0, left_q, right_q};
            default:    outfifo_data = 32'd0;
        endcase
        grant_id  = grant_q;
        busy      = (state_q != IDLE);
        pkt_count = cnt_q;
    end

endmodule

// File: tb/tb_fifo_serial_arbiter.sv
// Scoreboard bench: every accepted request queues its two expected output
// words, which are popped and compared as the arbiter writes them.
module tb_fifo_serial_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        req0_valid, req1_valid;
    logic [9:0]  req0_x, req0_y, req1_x, req1_y;
    logic [7:0]  req0_left, req0_right, req1_left, req1_right;
    logic        req0_ready, req1_ready;
    logic        outfifo_full;
    logic        outfifo_wrreq;
    logic [31:0] outfifo_data;
    logic        grant_id;
    logic        busy;
    logic [15:0] pkt_count;

    logic        fp_enable, fp_v0, fp_v1;
    logic [9:0]  fp_x, fp_y;
    logic [7:0]  fp_l, fp_r;
    logic        fp_full;
    logic        fp_r0, fp_r1, fp_wr, fp_gid, fp_busy;
    logic [31:0] fp_data;
    logic [15:0] fp_cnt;

    typedef struct {
        logic [31:0] w;
        logic        g;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_serial_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
        .req0_left(req0_left), .req0_right(req0_right), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
        .req1_left(req1_left), .req1_right(req1_right), .req1_ready(req1_ready),
        .outfifo_full(outfifo_full), .outfifo_wrreq(outfifo_wrreq),
        .outfifo_data(outfifo_data), .grant_id(grant_id), .busy(busy),
        .pkt_count(pkt_count)
    );

    fifo_serial_arbiter #(.FIXED_PRIO(1), .CNT_W(16)) dut_fp (
        .clk(clk), .reset_n(reset_n), .enable(fp_enable),
        .req0_valid(fp_v0), .req0_x(fp_x), .req0_y(fp_y),
        .req0_left(fp_l), .req0_right(fp_r), .req0_ready(fp_r0),
        .req1_valid(fp_v1), .req1_x(fp_y), .req1_y(fp_x),
        .req1_left(fp_r), .req1_right(fp_l), .req1_ready(fp_r1),
        .outfifo_full(fp_full), .outfifo_wrreq(fp_wr),
        .outfifo_data(fp_data), .grant_id(fp_gid), .busy(fp_busy),
        .pkt_count(fp_cnt)
    );

    function automatic logic [31:0] coord(input logic [9:0] x, input logic [9:0] y);
        return {6'b0, y, 6'b0, x};
    endfunction

    function automatic logic [31:0] pix(input logic [7:0] l, input logic [7:0] r);
        return {1'b1, 15'b0, l, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (req0_valid & req0_ready) begin
                exp_q.push_back('{coord(req0_x, req0_y), 1'b0});
                exp_q.push_back('{pix(req0_left, req0_right), 1'b0});
            end
            if (req1_valid & req1_ready) begin
                exp_q.push_back('{coord(req1_x, req1_y), 1'b1});
                exp_q.push_back('{pix(req1_left, req1_right), 1'b1});
            end
            if (req0_ready | req1_ready)
                check("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
            if (!enable)
                check("rdy_en_low", {31'b0, req0_ready | req1_ready}, 32'd0);
            if (outfifo_full)
                check("wr_when_full", {31'b0, outfifo_wrreq}, 32'd0);
            if (outfifo_wrreq) begin
                check("wr_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", outfifo_data, e.w);
                    check("gid", {31'b0, grant_id}, {31'b0, e.g});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input bit which);
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("hs_timeout", {31'b0, ok}, 32'd1);
        tick();
        if (which == 0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 50) begin
            tick();
            k++;
        end
        check("idle_timeout", {31'b0, k < 50}, 32'd1);
    endtask

    initial begin
        int n, cyc, nr, nb, nw, rc, wc;
        bit h0, h1, r;
        logic lg[16];
        logic [15:0] base;

        reset_n = 1'b0; enable = 1'b1; outfifo_full = 1'b0;
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd2; req0_left = 8'd3; req0_right = 8'd4;
        req1_valid = 1'b1; req1_x = 10'd9; req1_y = 10'd8; req1_left = 8'd7; req1_right = 8'd6;
        fp_enable = 1'b0; fp_v0 = 1'b0; fp_v1 = 1'b0; fp_full = 1'b0;
        fp_x = 10'd11; fp_y = 10'd22; fp_l = 8'h33; fp_r = 8'h44;
        #2;
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        check("rst_wrreq", {31'b0, outfifo_wrreq}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cnt", {16'b0, pkt_count}, 32'd0);
        check("rst_gid", {31'b0, grant_id}, 32'd0);
        check("rst_data", outfifo_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Round-robin contention from reset: 0,1,0,1
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            h0 = req0_valid & req0_ready;
            h1 = req1_valid & req1_ready;
            if (h0 | h1) begin lg[n] = h1; n++; end
            tick();
            if (h0) begin req0_x += 10'd7; req0_y += 10'd5; req0_left += 8'd17; req0_right -= 8'd3; end
            if (h1) begin req1_x += 10'd13; req1_y += 10'd1; req1_left ^= 8'hF0; req1_right += 8'd9; end
            if (n == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", n, 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", {31'b0, lg[i]}, i % 2);
        wait_idle();
        check("rr_pkts", {16'b0, pkt_count}, 32'd4);

        // Fixed priority: req0 wins every tie
        fp_v0 = 1'b1; fp_v1 = 1'b1; fp_enable = 1'b1; n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (fp_r0 | fp_r1) begin lg[n] = fp_r1; n++; end
            tick();
        end
        fp_v0 = 1'b0; fp_v1 = 1'b0;
        check("fp_count", {31'b0, n >= 4}, 32'd1);
        for (int i = 0; i < 4; i++) check("fp_order", {31'b0, lg[i]}, 32'd0);

        // Single packet with latency check
        base = pkt_count;
        req0_x = 10'd5; req0_y = 10'd3; req0_left = 8'hAA; req0_right = 8'h55; req0_valid = 1'b1;
        nr = 0; nb = 0; nw = 0; rc = -1; wc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req0_ready) begin nr++; rc = c; end
            if (busy) nb++;
            if (outfifo_wrreq) begin if (nw == 0) wc = c; nw++; end
            r = req0_ready;
            tick();
            if (r) req0_valid = 1'b0;
        end
        check("single_ready_cycles", nr, 32'd1);
        check("single_busy_cycles", nb, 32'd2);
        check("single_writes", nw, 32'd2);
        check("single_latency", wc, rc + 1);
        check("single_cnt", {16'b0, pkt_count}, {16'b0, base + 16'd1});

        // Backpressure stall of 5 cycles in SEND_COORD
        req1_x = 10'h3FF; req1_y = 10'h200; req1_left = 8'h01; req1_right = 8'hFE; req1_valid = 1'b1;
        handshake(1);
        outfifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_stall_wr", {31'b0, outfifo_wrreq}, 32'd0);
            check("bp_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        outfifo_full = 1'b0;
        @(negedge clk);
        check("bp_coord_wr", {31'b0, outfifo_wrreq}, 32'd1);
        check("bp_coord", outfifo_data, 32'h0200_03FF);
        tick(); @(negedge clk);
        check("bp_pix_wr", {31'b0, outfifo_wrreq}, 32'd1);
        check("bp_pix", outfifo_data, 32'h8000_01FE);
        tick(); @(negedge clk);
        check("bp_done", {31'b0, outfifo_wrreq}, 32'd0);
        wait_idle();

        // Full for one cycle between the two words
        req0_x = 10'h123; req0_y = 10'h0AB; req0_left = 8'h5A; req0_right = 8'hC3; req0_valid = 1'b1;
        handshake(0);
        @(negedge clk);
        check("tg_coord", outfifo_data, 32'h00AB_0123);
        tick(); outfifo_full = 1'b1;
        @(negedge clk);
        check("tg_stall_wr", {31'b0, outfifo_wrreq}, 32'd0);
        check("tg_stall_busy", {31'b0, busy}, 32'd1);
        tick(); outfifo_full = 1'b0;
        @(negedge clk);
        check("tg_pix_wr", {31'b0, outfifo_wrreq}, 32'd1);
        check("tg_pix", outfifo_data, 32'h8000_5AC3);
        wait_idle();

        // enable dropped during SEND_PIX with req1 waiting
        base = pkt_count;
        req0_x = 10'd77; req0_y = 10'd66; req0_left = 8'h12; req0_right = 8'h34; req0_valid = 1'b1;
        handshake(0);
        req1_x = 10'd40; req1_y = 10'd50; req1_left = 8'h9A; req1_right = 8'hBC; req1_valid = 1'b1;
        tick(); enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("en_low_ready1", {31'b0, req1_ready}, 32'd0);
            tick();
        end
        check("en_low_done", {31'b0, busy}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("en_back_ready1", {31'b0, req1_ready}, 32'd1);
        tick(); req1_valid = 1'b0;
        wait_idle();
        check("en_cnt", {16'b0, pkt_count}, {16'b0, base + 16'd2});

        // Asynchronous reset pulse inside SEND_PIX
        req0_x = 10'd300; req0_y = 10'd400; req0_left = 8'hDE; req0_right = 8'hAD; req0_valid = 1'b1;
        handshake(0);
        tick();
        check("pre_rst_wr", {31'b0, outfifo_wrreq}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_wr", {31'b0, outfifo_wrreq}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_cnt", {16'b0, pkt_count}, 32'd0);
        exp_q.delete();
        #1 reset_n = 1'b1;
        req1_x = 10'd21; req1_y = 10'd12; req1_left = 8'h0F; req1_right = 8'hF0; req1_valid = 1'b1;
        handshake(1);
        @(negedge clk);
        check("post_rst_first_wr", {31'b0, outfifo_wrreq}, 32'd1);
        check("post_rst_coord_tag", {31'b0, outfifo_data[31]}, 32'd0);
        wait_idle();
        check("post_rst_cnt", {16'b0, pkt_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
